// File: rtl/demux_deser_16.sv
// Serial-to-parallel collector: steers each accepted bit into one lane of a 16-bit word and
// presents the word with a valid/ready handshake. Define DESER_PARITY_EN for a trailing parity bit.
module demux_deser_16 #(
    parameter int unsigned LSB_FIRST = 1,
    parameter int unsigned IDX_W     = 4  // only 4 (16 lanes) is supported
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [15:0]      word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic [IDX_W-1:0] bit_idx,
    output logic             overrun,
    output logic             parity_err
);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StHold    = 2'd2,
        StParity  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StHold    = 2'd2
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [15:0]      word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic             parity_q, parity_d;
    logic [3:0]       lane;
    logic [15:0]      lane_we;

    // Lane select and one-hot write enable gated by bit_valid.
    assign lane    = (LSB_FIRST != 0) ? 4'(idx_q) : 4'(4'd15 - 4'(idx_q));
    assign lane_we = (16'd1 << lane) & {16{bit_valid}};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            word_q    <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        parity_d  = parity_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StCollect;
                    idx_d    = '0;
                    word_d   = '0;
                    parity_d = 1'b0;
                end
            end
            StCollect: begin
                if (start) begin
                    idx_d    = '0;
                    word_d   = '0;
                    parity_d = 1'b0;
                end else if (bit_valid) begin
                    word_d = (word_q & ~lane_we) | (lane_we & {16{bit_in}});
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == '1) begin
`ifdef DESER_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StHold;
`endif
                    end
                end
            end
`ifdef DESER_PARITY_EN
            StParity: begin
                if (start) begin
                    state_d  = StCollect;
                    idx_d    = '0;
                    word_d   = '0;
                    parity_d = 1'b0;
                end else if (bit_valid) begin
                    parity_d = (^word_q) ^ bit_in;
                    state_d  = StHold;
                end
            end
`endif
            StHold: begin
                // A bit arriving while a word waits is dropped and flagged.
                if (bit_valid) begin
                    overrun_d = 1'b1;
                end
                if (word_ready) begin
                    if (start) begin
                        state_d  = StCollect;
                        idx_d    = '0;
                        word_d   = '0;
                        parity_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == StHold);
`ifdef DESER_PARITY_EN
    assign busy       = (state_q == StCollect) || (state_q == StParity);
`else
    assign busy       = (state_q == StCollect);
`endif
    assign bit_idx    = idx_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_q;

endmodule

// File: tb/tb_demux_deser_16.sv
// Self-checking bench for demux_deser_16: runs an LSB-first and an MSB-first instance side by
// side and compares both against a bit-stream reference model.
module tb_demux_deser_16;

    logic        clock = 1'b0;
    logic        reset, start, bit_in, bit_valid, word_ready;
    logic [15:0] wo1, wo0;
    logic        wv1, wv0, b1, b0, ov1, ov0, pe1, pe0;
    logic [3:0]  ix1, ix0;
    logic        pflip;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    demux_deser_16 #(.LSB_FIRST(1), .IDX_W(4)) dut_lsb (
        .clock(clock), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_out(wo1), .word_valid(wv1), .word_ready(word_ready), .busy(b1), .bit_idx(ix1),
        .overrun(ov1), .parity_err(pe1)
    );

    demux_deser_16 #(.LSB_FIRST(0), .IDX_W(4)) dut_msb (
        .clock(clock), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_out(wo0), .word_valid(wv0), .word_ready(word_ready), .busy(b0), .bit_idx(ix0),
        .overrun(ov0), .parity_err(pe0)
    );

    // Word built from the first n stream bits (stream bit i is the i-th bit sent).
    function automatic logic [15:0] assemble(input logic [15:0] stream, input int n,
                                             input bit lsb);
        logic [15:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (lsb) r[i] = stream[i];
            else r[15-i] = stream[i];
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    // gap: 0 none, 1 one idle cycle between bits, 2 random 0..2 idle cycles.
    task automatic send_word(input logic [15:0] stream, input int gap);
        int n;
        start = 1'b1; bit_valid = 1'b0;
        cyc();
        start = 1'b0;
        checks++;
        if ({b1, b0, ix1, ix0, wo1, wo0, pe1, pe0} !== {2'b11, 8'h00, 32'h0, 2'b00}) begin
            errors++;
            $display("FAIL start_state got busy=%b%b idx=%h/%h word=%h/%h perr=%b%b",
                     b1, b0, ix1, ix0, wo1, wo0, pe1, pe0);
        end
        for (int i = 0; i < 16; i++) begin
            bit_in = stream[i]; bit_valid = 1'b1;
            cyc();
            bit_valid = 1'b0;
            checks++;
            if ({ix1, ix0, wo1, wo0} !== {4'((i + 1) % 16), 4'((i + 1) % 16),
                                          assemble(stream, i + 1, 1'b1),
                                          assemble(stream, i + 1, 1'b0)}) begin
                errors++;
                $display("FAIL collect_bit%0d got idx=%h/%h word=%h/%h want idx=%h word=%h/%h",
                         i, ix1, ix0, wo1, wo0, 4'((i + 1) % 16),
                         assemble(stream, i + 1, 1'b1), assemble(stream, i + 1, 1'b0));
            end
            if (i < 15) begin
                checks++;
                if ({wv1, wv0} !== 2'b00) begin
                    errors++;
                    $display("FAIL early_valid bit%0d got %b%b want 00", i, wv1, wv0);
                end
                n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (n) begin
                    bit_in = 1'($urandom);
                    cyc();
                end
            end
        end
`ifdef DESER_PARITY_EN
        checks++;
        if ({b1, b0, wv1, wv0} !== 4'b1100) begin
            errors++;
            $display("FAIL parity_wait got busy=%b%b valid=%b%b want 11 00", b1, b0, wv1, wv0);
        end
        bit_in = (^stream) ^ pflip; bit_valid = 1'b1;
        cyc();
        bit_valid = 1'b0;
`endif
        bit_in = 1'b0;
    endtask

    task automatic check_held(input logic [15:0] stream, input string name);
        logic [1:0] pe_exp;
`ifdef DESER_PARITY_EN
        pe_exp = {pflip, pflip};
`else
        pe_exp = 2'b00;
`endif
        checks++;
        if ({wv1, wv0, b1, b0, ix1, ix0, pe1, pe0} !== {4'b1100, 8'h00, pe_exp}) begin
            errors++;
            $display("FAIL %s_flags got valid=%b%b busy=%b%b idx=%h/%h perr=%b%b want 11 00 0 %b",
                     name, wv1, wv0, b1, b0, ix1, ix0, pe1, pe0, pe_exp);
        end
        checks++;
        if ({wo1, wo0} !== {assemble(stream, 16, 1'b1), assemble(stream, 16, 1'b0)}) begin
            errors++;
            $display("FAIL %s_word got %h/%h want %h/%h", name, wo1, wo0,
                     assemble(stream, 16, 1'b1), assemble(stream, 16, 1'b0));
        end
    endtask

    task automatic handshake(input string name);
        word_ready = 1'b1;
        cyc();
        word_ready = 1'b0;
        checks++;
        if ({wv1, wv0, b1, b0} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_release got valid=%b%b busy=%b%b want 0", name, wv1, wv0, b1, b0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wo1, wo0, wv1, wv0, b1, b0, ix1, ix0, ov1, ov0, pe1, pe0} !== '0) begin
            errors++;
            $display("FAIL reset got word=%h/%h valid=%b%b busy=%b%b idx=%h/%h ovr=%b%b perr=%b%b",
                     wo1, wo0, wv1, wv0, b1, b0, ix1, ix0, ov1, ov0, pe1, pe0);
        end
    endtask

    task automatic test_idle_ignore();
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (3) cyc();
        bit_valid = 1'b0; bit_in = 1'b0;
        checks++;
        if ({wo1, wo0, wv1, wv0, b1, b0, ix1, ix0, ov1, ov0} !== '0) begin
            errors++;
            $display("FAIL idle_ignore got word=%h/%h valid=%b%b busy=%b%b idx=%h/%h ovr=%b%b",
                     wo1, wo0, wv1, wv0, b1, b0, ix1, ix0, ov1, ov0);
        end
    endtask

    task automatic test_lsb_first();
        pflip = 1'b0;
        send_word(16'hA5C3, 0);
        check_held(16'hA5C3, "a5c3");
        checks++;
        if ({wo1, wo0} !== {16'hA5C3, 16'hC3A5}) begin
            errors++;
            $display("FAIL a5c3_const got %h/%h want a5c3/c3a5", wo1, wo0);
        end
        handshake("a5c3");
    endtask

    task automatic test_gapped();
        pflip = 1'b0;
        send_word(16'h0001, 1);
        check_held(16'h0001, "gapped");
        handshake("gapped");
    endtask

    task automatic test_overrun();
        pflip = 1'b0;
        send_word(16'h3C96, 0);
        word_ready = 1'b0;
        repeat (5) cyc();
        bit_valid = 1'b1; bit_in = 1'b1;
        cyc();
        bit_valid = 1'b0; bit_in = 1'b0;
        check_held(16'h3C96, "overrun_hold");
        checks++;
        if ({ov1, ov0} !== 2'b11) begin
            errors++;
            $display("FAIL overrun_flag got %b%b want 11", ov1, ov0);
        end
        word_ready = 1'b1; start = 1'b1;
        cyc();
        word_ready = 1'b0; start = 1'b0;
        checks++;
        if ({wv1, wv0, b1, b0, ix1, ix0, wo1, wo0, ov1, ov0} !== {4'b0011, 8'h00, 32'h0, 2'b11})
        begin
            errors++;
            $display("FAIL back_to_back got valid=%b%b busy=%b%b idx=%h/%h word=%h/%h ovr=%b%b",
                     wv1, wv0, b1, b0, ix1, ix0, wo1, wo0, ov1, ov0);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            cyc();
        end
        reset = 1'b1; start = 1'b1;
        cyc();
        reset = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        checks++;
        if ({wo1, wo0, wv1, wv0, b1, b0, ix1, ix0, ov1, ov0, pe1, pe0} !== '0) begin
            errors++;
            $display("FAIL reset_mid got word=%h/%h valid=%b%b busy=%b%b idx=%h/%h ovr=%b%b",
                     wo1, wo0, wv1, wv0, b1, b0, ix1, ix0, ov1, ov0);
        end
        pflip = 1'b0;
        send_word(16'hFFFF, 0);
        check_held(16'hFFFF, "ffff");
        handshake("ffff");
    endtask

    task automatic test_restart();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            cyc();
        end
        start = 1'b1;
        cyc();
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        checks++;
        if ({b1, b0, ix1, ix0, wo1, wo0} !== {2'b11, 8'h00, 32'h0}) begin
            errors++;
            $display("FAIL restart got busy=%b%b idx=%h/%h word=%h/%h want 11 0 0",
                     b1, b0, ix1, ix0, wo1, wo0);
        end
        pflip = 1'b0;
        send_word(16'h8421, 0);
        check_held(16'h8421, "restart");
        handshake("restart");
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        pflip = 1'b1;
        send_word(16'h0007, 0);
        check_held(16'h0007, "parity_bad");
        handshake("parity_bad");
        checks++;
        if ({pe1, pe0} !== 2'b11) begin
            errors++;
            $display("FAIL parity_sticky got %b%b want 11", pe1, pe0);
        end
        pflip = 1'b0;
        send_word(16'h0007, 0);
        check_held(16'h0007, "parity_good");
        handshake("parity_good");
    endtask
`endif

    task automatic test_random();
        logic [15:0] w;
        for (int k = 0; k < 12; k++) begin
            w = 16'($urandom);
            pflip = 1'($urandom);
            send_word(w, 2);
            check_held(w, "random");
            handshake("random");
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
        pflip = 1'b0;
        test_reset();
        test_idle_ignore();
        test_lsb_first();
        test_gapped();
        test_overrun();
        test_reset_mid();
        test_restart();
`ifdef DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_deser_16.md
Name: demux_deser_16

Overview:
- Serial-to-parallel collector: the inverse of the 16:1 bit-select path.
- Each accepted serial bit is steered through a 4-to-16 one-hot decode into one lane of a 16-bit capture register. The lane is selected by an internal 4-bit index counter.
- After 16 bits, the assembled word is presented with a valid/ready handshake.
- Sits beside the multdiv datapath to rebuild operands or results from bit-serial streams.

Parameters:
- LSB_FIRST, 1: 1 = first bit lands in word bit 0; 0 = first bit lands in bit 15.
- IDX_W, 4: index counter width. Fixed at 4 for a 16-lane word; other values are unsupported.

Ports:
- clock  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on a rising edge where it is high.
- start  input  1  begins a new 16-bit collection.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- word_out  output  16  assembled word.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  consumer accepts word_out.
- busy  output  1  high while collecting.
- bit_idx  output  4  current index counter value.
- overrun  output  1  sticky: a bit arrived while a word was waiting in HOLD.
- parity_err  output  1  see Optional Feature.

Behaviour:
- Reset:
  - state goes to IDLE.
  - word_out, bit_idx = 0.
  - word_valid, busy, overrun, parity_err = 0.
  - Reset wins over every other input in the same cycle. Reset mid-collection discards the partial word.
- States: IDLE, COLLECT, HOLD (plus PARITY under the macro). busy = (state == COLLECT or PARITY).
- IDLE:
  - bit_valid is ignored; overrun is not set.
  - start=1: bit_idx <= 0, word_out <= 0, next state COLLECT.
- COLLECT:
  - bit_valid=1: lane L gets bit_in; all other lanes hold. L = bit_idx if LSB_FIRST=1, else 15 - bit_idx. Then bit_idx <= bit_idx + 1.
  - Write enable comes from a one-hot decode of bit_idx gated by bit_valid. Exactly one lane is written per accepted bit.
  - bit_valid=0: no change.
  - Bit accepted with bit_idx = 15: bit_idx wraps to 0 and next state is HOLD. word_valid rises on the following edge, i.e. the cycle after the 16th bit. Latency from the 16th bit to word_valid is one cycle.
  - start=1 in COLLECT restarts: bit_idx <= 0, word_out <= 0, and bit_valid that cycle is ignored. start has priority over bit_valid.
- HOLD:
  - word_valid=1; word_out is stable until the handshake.
  - word_valid & word_ready: word_valid <= 0. Next state is COLLECT if start=1 that cycle (with bit_idx = 0 and word_out cleared on the same edge), otherwise IDLE.
  - start without word_ready is ignored.
  - bit_valid=1 in HOLD: the bit is dropped and overrun <= 1. overrun stays set until reset.
- bit_idx is visible in all states. It equals the count of bits accepted in the current word, modulo 16.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - After the 16th data bit, state goes to PARITY instead of HOLD.
  - The next accepted bit_valid bit is the even-parity bit. parity_err <= (^word_out) ^ bit_in, then state goes to HOLD.
  - parity_err holds until the next start or reset.
  - start in PARITY restarts as in COLLECT.
- Not defined: there is no PARITY state and parity_err is constant 0.

Test Plan:
- LSB_FIRST=1: start, then 16 consecutive valid bits of 16'hA5C3 LSB first -> word_valid=1 one cycle after the last bit, word_out=16'hA5C3, bit_idx=0, busy=0.
- LSB_FIRST=0: same stream -> word_out=16'hC3A5 (bit-reversed).
- bit_valid gapped every other cycle while sending 16'h0001 -> word_valid after the 16th accepted bit only, word_out=16'h0001. Intermediate bit_idx checks: 3 after 3 accepted bits, 8 after 8.
- Complete a word, hold word_ready=0 for 5 cycles, pulse bit_valid once -> word_out stable, overrun=1. Then word_ready=1 with start=1 -> word_valid=0 and busy=1 on the next cycle.
- Reset asserted after 7 bits -> next cycle all outputs 0, state IDLE. A fresh 16-bit stream of 16'hFFFF then yields word_out=16'hFFFF.
- DESER_PARITY_EN defined: send 16'h0007 then parity bit 0 -> parity_err=1. Repeat with parity bit 1 -> parity_err=0, word_out=16'h0007.
